sobel_line_feeder: RTL and testbench
====================================

# sobel_line_feeder

- Producer side of the Sobel 3x3 window path: accepts a raster pixel stream and holds two previous image rows in circular line buffers.
- Per accepted pixel, emits a column triple (current row, one row above, two rows above) with a one-cycle `done_o` strobe, feeding the 3x3 window modulator's `d0_i`/`d1_i`/`d2_i`/`done_i` inputs.
- Rows above the top of the frame read as zero.
- After the frame's last pixel, drives a flush tail of zero pixels so the downstream window can drain the bottom row.

## Interface

- `ROWS`, default 5: image height in rows (480 for VGA).
- `COLS`, default 6: image width in pixels (640 for VGA); sets line-buffer depth.
- `FLUSH_LEN`, default `COLS+1`: number of injected zero beats after the last pixel.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pix_i`  in  8  input pixel.
- `valid_i`  in  1  `pix_i` valid.
- `ready_o`  out  1  block accepts pixels; transfer when `valid_i && ready_o`.
- `d0_o`  out  8  current-row pixel.
- `d1_o`  out  8  same column, previous row (line buffer 1).
- `d2_o`  out  8  same column, two rows back (line buffer 2).
- `done_o`  out  1  one-cycle strobe; `d0_o`..`d2_o` are valid on this cycle.
- `sof_o`  out  1  with `done_o` for pixel (row 0, col 0).
- `eof_o`  out  1  with the final `done_o` of the frame.

## Operation

- Storage:
  - `lb1` and `lb2` are COLS x 8 RAMs, both addressed by column counter `col` (0..COLS-1).
  - Row counter `row` runs 0..ROWS-1.
- Per beat, read-before-write at `col`:
  - `d0_o <= pix`, `d1_o <= lb1[col]`, `d2_o <= lb2[col]`.
  - `lb2[col] <= lb1[col]`, `lb1[col] <= pix`.
- Masking, not RAM clearing:
  - `row==0`: `d1_o` and `d2_o` forced to 0.
  - `row==1`: `d2_o` forced to 0.
- Counters:
  - `col` wraps COLS-1 -> 0 and then increments `row`.
  - `row` wraps ROWS-1 -> 0 at frame end.
- State machine:
  - `IDLE`: `ready_o`=1. First accepted beat moves to `RUN` and sets `sof_o`.
  - `RUN`: `ready_o`=1. The accepted beat at (ROWS-1, COLS-1) moves to `FLUSH`.
  - `FLUSH`: `ready_o`=0. Issues exactly FLUSH_LEN beats, one per cycle, independent of `valid_i`. Each beat has `pix`=0 and uses the normal read/write path with `col` continuing to wrap and no masking. The last flush beat sets `eof_o`, clears `row`/`col` and returns to `IDLE`.
- `valid_i` while `ready_o`=0 is ignored: no beat, and the data is not captured.
- Gaps in `valid_i` produce no beat, and counters hold.

## Timing

- Latency: 1 cycle from the accepting edge to `done_o`/data. Outputs are registered.
- `done_o`, `sof_o`, `eof_o` are single-cycle pulses. Data outputs hold their last value between strobes.
- `ready_o` drops in the cycle after the last pixel is accepted. It returns high in the cycle after the last flush beat.
- Throughput: one beat per cycle. A full frame with back-to-back `valid_i` occupies ROWS*COLS + FLUSH_LEN cycles.
- Reset values:
  - `d0_o`, `d1_o`, `d2_o` = 0.
  - `done_o`, `sof_o`, `eof_o` = 0.
  - `ready_o` = 1.
  - State `IDLE`; `row` = `col` = 0.
  - RAM contents undefined; masking covers them.
- Reset mid-frame or mid-flush: all of the above on the next edge. The remaining flush beats are abandoned, and the next accepted pixel is (0,0) with `sof_o`.

## Configuration

- `SOBEL_FEEDER_FLUSH_EN`
  - Defined: `FLUSH` state present as above.
  - Undefined: `FLUSH` state removed; `ready_o` is tied to 1. `eof_o` pulses with the `done_o` of pixel (ROWS-1, COLS-1), and the next cycle may accept pixel (0,0) of the next frame.

## Test plan

All scenarios use ROWS=5, COLS=6, macro defined unless stated.

- Pixels 1..30 back-to-back from reset -> `done_o` 1 cycle after each. Pixel 1 gives `sof_o`=1, `d1_o`=`d2_o`=0. Pixel 8 gives d0=8, d1=2, d2=0. Pixel 14 gives d0=14, d1=8, d2=2.
- Continue after pixel 30 -> `ready_o`=0 for 7 cycles, and `valid_i`=1 with `pix_i`=99 during them is not captured. First flush beat gives d0=0, d1=25, d2=19. 7th flush beat: `eof_o`=1, then `ready_o`=1.
- Same frame with `valid_i` toggling 1/0 -> identical output sequence, each delayed to its accept cycle. No `done_o` on gap cycles.
- Second frame of pixels 101..130 -> pixel 101 gives d1=0, d2=0 despite stale RAM. Pixel 107 gives d1=101, d2=0.
- `rst` pulsed after pixel 17 -> outputs 0, `ready_o`=1. Next pixel gives `sof_o`=1 and d1=d2=0.
- Macro undefined, two frames back-to-back -> `eof_o` on pixel 30's strobe, pixel 101 accepted the next cycle with `sof_o`, `ready_o` never low.

Source files
------------

// File: rtl/sobel_line_feeder.sv
// Raster-to-column feeder for the Sobel 3x3 window: two circular line buffers supply the
// rows above each pixel. Optional zero flush tail is enabled by SOBEL_FEEDER_FLUSH_EN.
module sobel_line_feeder #(
   parameter int unsigned ROWS = 5,
   parameter int unsigned COLS = 6
`ifdef SOBEL_FEEDER_FLUSH_EN
   ,
   parameter int unsigned FLUSH_LEN = COLS + 1
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pix_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic [7:0] d0_o,
   output logic [7:0] d1_o,
   output logic [7:0] d2_o,
   output logic       done_o,
   output logic       sof_o,
   output logic       eof_o
);

   localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

   state_e            state_q;
   logic [ColW-1:0]   col_q;
   logic [RowW-1:0]   row_q;
   logic [7:0]        d0_q, d1_q, d2_q;
   logic              done_q, sof_q, eof_q;
   logic [7:0]        lb1 [COLS];
   logic [7:0]        lb2 [COLS];

   logic              in_flush;
   logic              accept;
   logic              beat;
   logic [7:0]        beat_pix;
   logic              col_last;
   logic              row_last;

`ifdef SOBEL_FEEDER_FLUSH_EN
   localparam int unsigned FlushW = $clog2(FLUSH_LEN + 1);

   logic              ready_q;
   logic [FlushW-1:0] flush_cnt_q;
   logic              flush_last;

   assign ready_o    = ready_q;
   assign flush_last = (flush_cnt_q == FlushW'(FLUSH_LEN - 1));
`else
   assign ready_o    = 1'b1;
`endif

   always_comb begin
      in_flush = 1'b0;
`ifdef SOBEL_FEEDER_FLUSH_EN
      in_flush = (state_q == StFlush);
`endif
      accept   = valid_i && ready_o && !in_flush;
      beat     = accept || in_flush;
      beat_pix = in_flush ? 8'd0 : pix_i;
      col_last = (col_q == ColW'(COLS - 1));
      row_last = (row_q == RowW'(ROWS - 1));
   end

   // Line buffers hold no reset; stale contents are hidden by the row masks.
   always_ff @(posedge clk) begin
      if (beat) begin
         lb2[col_q] <= lb1[col_q];
         lb1[col_q] <= beat_pix;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         col_q       <= '0;
         row_q       <= '0;
         d0_q        <= 8'd0;
         d1_q        <= 8'd0;
         d2_q        <= 8'd0;
         done_q      <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
`ifdef SOBEL_FEEDER_FLUSH_EN
         ready_q     <= 1'b1;
         flush_cnt_q <= '0;
`endif
      end else begin
         done_q <= beat;
         sof_q  <= 1'b0;
         eof_q  <= 1'b0;

         if (beat) begin
            d0_q  <= beat_pix;
            d1_q  <= (row_q == '0 && !in_flush) ? 8'd0 : lb1[col_q];
            d2_q  <= (row_q <= RowW'(1) && !in_flush) ? 8'd0 : lb2[col_q];
            col_q <= col_last ? '0 : col_q + ColW'(1);
         end

         if (accept) begin
            if (state_q == StIdle) begin
               sof_q <= 1'b1;
            end
            state_q <= StRun;
            if (col_last) begin
               row_q <= row_last ? '0 : row_q + RowW'(1);
               if (row_last) begin
`ifdef SOBEL_FEEDER_FLUSH_EN
                  state_q     <= StFlush;
                  ready_q     <= 1'b0;
                  flush_cnt_q <= '0;
`else
                  eof_q       <= 1'b1;
                  state_q     <= StIdle;
`endif
               end
            end
         end

`ifdef SOBEL_FEEDER_FLUSH_EN
         // Flush beats ignore valid_i; the last one closes the frame.
         if (in_flush) begin
            flush_cnt_q <= flush_cnt_q + FlushW'(1);
            if (flush_last) begin
               eof_q   <= 1'b1;
               row_q   <= '0;
               col_q   <= '0;
               state_q <= StIdle;
               ready_q <= 1'b1;
            end
         end
`endif
      end
   end

   assign d0_o   = d0_q;
   assign d1_o   = d1_q;
   assign d2_o   = d2_q;
   assign done_o = done_q;
   assign sof_o  = sof_q;
   assign eof_o  = eof_q;

endmodule

// File: tb/tb_sobel_line_feeder.sv
// Directed bench for sobel_line_feeder; covers both SOBEL_FEEDER_FLUSH_EN settings.
`timescale 1ns/1ps
module tb_sobel_line_feeder;

   localparam int ROWS = 5;
   localparam int COLS = 6;
`ifdef SOBEL_FEEDER_FLUSH_EN
   localparam int FLUSH_LEN = COLS + 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pix_i;
   logic       valid_i;
   logic       ready_o;
   logic [7:0] d0_o, d1_o, d2_o;
   logic       done_o, sof_o, eof_o;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   sobel_line_feeder #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pix_i   (pix_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .d0_o    (d0_o),
      .d1_o    (d1_o),
      .d2_o    (d2_o),
      .done_o  (done_o),
      .sof_o   (sof_o),
      .eof_o   (eof_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pixel value at (r - back, c) of a frame whose (0,0) pixel is base; 0 above the frame.
   function automatic logic [7:0] px(input int base, input int r, input int c, input int back);
      if (r - back < 0) return 8'd0;
      return 8'(base + (r - back) * COLS + c);
   endfunction

   task automatic test_reset();
      rst = 1'b1; valid_i = 1'b0; pix_i = 8'd0;
      step(); step();
      rst = 1'b0;
      checks++;
      if ({d0_o, d1_o, d2_o} !== 24'd0)
         $display("FAIL reset_data: got %0d/%0d/%0d, expected 0/0/0", d0_o, d1_o, d2_o);
      else passes++;
      checks++;
      if ({done_o, sof_o, eof_o, ready_o} !== 4'b0001)
         $display("FAIL reset_ctrl: done/sof/eof/ready=%b, expected 0001",
                  {done_o, sof_o, eof_o, ready_o});
      else passes++;
   endtask

   // One full frame starting at base, optionally with an idle cycle before every pixel.
   task automatic test_frame(input int base, input bit gaps, input string tag);
      int r, c;
      logic       exp_eof;
      logic [7:0] e0, e1, e2;
      for (int i = 0; i < ROWS * COLS; i++) begin
         r = i / COLS;
         c = i % COLS;
         if (gaps) begin
            valid_i = 1'b0; pix_i = 8'hEE;
            step();
            checks++;
            if (done_o !== 1'b0) $display("FAIL %s gap %0d: done=%b, expected 0", tag, i, done_o);
            else passes++;
         end
         checks++;
         if (ready_o !== 1'b1) $display("FAIL %s ready %0d: ready=%b, expected 1", tag, i, ready_o);
         else passes++;
         valid_i = 1'b1;
         pix_i   = 8'(base + i);
         step();
         e0 = 8'(base + i);
         e1 = px(base, r, c, 1);
         e2 = px(base, r, c, 2);
`ifdef SOBEL_FEEDER_FLUSH_EN
         exp_eof = 1'b0;
`else
         exp_eof = (i == ROWS * COLS - 1);
`endif
         checks++;
         if (done_o !== 1'b1 || sof_o !== (i == 0) || eof_o !== exp_eof ||
             d0_o !== e0 || d1_o !== e1 || d2_o !== e2)
            $display("FAIL %s pix %0d: done=%b sof=%b eof=%b d=%0d/%0d/%0d, expected done=1 sof=%b eof=%b d=%0d/%0d/%0d",
                     tag, i, done_o, sof_o, eof_o, d0_o, d1_o, d2_o,
                     (i == 0), exp_eof, e0, e1, e2);
         else passes++;
      end
`ifdef SOBEL_FEEDER_FLUSH_EN
      // Stall data presented during the tail must not enter the pipeline.
      valid_i = 1'b1; pix_i = 8'd99;
      for (int k = 0; k < FLUSH_LEN; k++) begin
         checks++;
         if (ready_o !== 1'b0) $display("FAIL %s flush_ready %0d: ready=%b, expected 0", tag, k, ready_o);
         else passes++;
         step();
         if (k < COLS) begin
            e1 = px(base, ROWS - 1, k, 0);
            e2 = px(base, ROWS - 2, k, 0);
         end else begin
            e1 = 8'd0;
            e2 = px(base, ROWS - 1, k - COLS, 0);
         end
         checks++;
         if (done_o !== 1'b1 || sof_o !== 1'b0 || eof_o !== (k == FLUSH_LEN - 1) ||
             d0_o !== 8'd0 || d1_o !== e1 || d2_o !== e2)
            $display("FAIL %s flush %0d: done=%b sof=%b eof=%b d=%0d/%0d/%0d, expected done=1 sof=0 eof=%b d=0/%0d/%0d",
                     tag, k, done_o, sof_o, eof_o, d0_o, d1_o, d2_o,
                     (k == FLUSH_LEN - 1), e1, e2);
         else passes++;
      end
      checks++;
      if (ready_o !== 1'b1) $display("FAIL %s post_flush_ready: ready=%b, expected 1", tag, ready_o);
      else passes++;
      valid_i = 1'b0;
      step();
      checks++;
      if (done_o !== 1'b0 || eof_o !== 1'b0)
         $display("FAIL %s post_flush_idle: done=%b eof=%b, expected 0 0", tag, done_o, eof_o);
      else passes++;
`endif
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 17; i++) begin
         valid_i = 1'b1; pix_i = 8'(1 + i);
         step();
      end
      checks++;
      if (done_o !== 1'b1 || d0_o !== 8'd17 || d1_o !== 8'd11 || d2_o !== 8'd5)
         $display("FAIL mid_pix17: done=%b d=%0d/%0d/%0d, expected done=1 d=17/11/5",
                  done_o, d0_o, d1_o, d2_o);
      else passes++;
      rst = 1'b1; valid_i = 1'b1; pix_i = 8'd55;
      step();
      rst = 1'b0; valid_i = 1'b0;
      checks++;
      if ({d0_o, d1_o, d2_o} !== 24'd0 || {done_o, sof_o, eof_o, ready_o} !== 4'b0001)
         $display("FAIL mid_reset_state: d=%0d/%0d/%0d done/sof/eof/ready=%b, expected 0/0/0 0001",
                  d0_o, d1_o, d2_o, {done_o, sof_o, eof_o, ready_o});
      else passes++;
      valid_i = 1'b1; pix_i = 8'd77;
      step();
      checks++;
      if (done_o !== 1'b1 || sof_o !== 1'b1 || d0_o !== 8'd77 || d1_o !== 8'd0 || d2_o !== 8'd0)
         $display("FAIL mid_first: done=%b sof=%b d=%0d/%0d/%0d, expected 1 1 77/0/0",
                  done_o, sof_o, d0_o, d1_o, d2_o);
      else passes++;
      pix_i = 8'd78;
      step();
      valid_i = 1'b0;
      checks++;
      if (done_o !== 1'b1 || sof_o !== 1'b0 || d0_o !== 8'd78 || d1_o !== 8'd0 || d2_o !== 8'd0)
         $display("FAIL mid_second: done=%b sof=%b d=%0d/%0d/%0d, expected 1 0 78/0/0",
                  done_o, sof_o, d0_o, d1_o, d2_o);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_frame(1, 1'b0, "frame1");
      test_frame(101, 1'b0, "frame2");
      test_frame(1, 1'b1, "gaps");
      test_mid_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $fatal(1);
   end

endmodule
